// File: rtl/cdb_result_queue.sv
// rtl/cdb_result_queue.sv - in-order result FIFO between one functional unit and the CDB scheduler
package cdb_pkg;
  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] value;
    logic        take_branch;
    logic [31:0] br_target;
  } CDB_packet_t;
endpackage

module cdb_result_queue
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  input  CDB_packet_t      enq_packet,
  output logic             ready,
  output logic             valid_out,
  output CDB_packet_t      out,
  input  logic             yumi_in,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  CDB_packet_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_enq;
  logic             do_deq;

  // Decode only from registered count, so ready never depends on yumi_in.
  assign ready     = (count != CNT_W'(DEPTH));
  assign valid_out = (count != '0);
  assign out       = valid_out ? mem[head] : '0;
  assign do_enq    = enq_valid & ready;
  assign do_deq    = yumi_in & valid_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + PTR_W'(1);
      if (do_deq) head <= head + PTR_W'(1);
      count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !flush) mem[tail] <= enq_packet;
  end

  // A dropped enqueue is an FU protocol slip, reported but not fatal.
  always @(posedge clk) begin
    if (reset && !flush) begin
      assert (!(enq_valid && !ready))
        else $warning("cdb_result_queue: enqueue dropped while full");
      assert (!(yumi_in && !valid_out))
        else $error("cdb_result_queue: yumi_in while queue empty");
    end
    if (reset) begin
      assert (count <= CNT_W'(DEPTH))
        else $error("cdb_result_queue: count out of range");
      assert (tail == head + count[PTR_W-1:0])
        else $error("cdb_result_queue: tail/head/count disagree");
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// tb/tb_cdb_result_queue.sv - directed vector bench for cdb_result_queue
module tb_cdb_result_queue;
  import cdb_pkg::*;

  logic        clk = 0;
  logic        reset = 0;
  logic        flush = 0;
  logic        enq_valid = 0;
  CDB_packet_t enq_packet = '0;
  logic        ready;
  logic        valid_out;
  CDB_packet_t out;
  logic        yumi_in = 0;
  logic [2:0]  count;

  cdb_result_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .enq_valid(enq_valid),
    .enq_packet(enq_packet), .ready(ready), .valid_out(valid_out),
    .out(out), .yumi_in(yumi_in), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        ev;
    logic [3:0]  rob;
    logic [31:0] val;
    logic        yu;
    logic        exp_v;
    logic        exp_r;
    logic [2:0]  exp_cnt;
    logic [3:0]  exp_rob;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic CDB_packet_t mk(input logic [3:0] rob, input logic [31:0] val);
    CDB_packet_t p;
    p.rob         = rob;
    p.value       = val;
    p.take_branch = val[0];
    p.br_target   = ~val;
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic r, input logic [2:0] c,
                         input CDB_packet_t p);
    chk({tag, " valid_out"}, 128'(valid_out), 128'(v));
    chk({tag, " ready"}, 128'(ready), 128'(r));
    chk({tag, " count"}, 128'(count), 128'(c));
    chk({tag, " out"}, 128'(out), 128'(p));
  endtask

  // Values with rob = low nibble of value; empty head shows all zeros.
  task automatic add(input logic fl, input logic ev, input logic [31:0] val, input logic yu,
                     input logic ev_o, input logic er, input logic [2:0] ec, input logic [31:0] eval);
    vec_t t;
    t.fl = fl; t.ev = ev; t.rob = val[3:0]; t.val = val; t.yu = yu;
    t.exp_v = ev_o; t.exp_r = er; t.exp_cnt = ec;
    t.exp_rob = eval[3:0]; t.exp_val = eval;
    vecs.push_back(t);
  endtask

  task automatic step(input logic fl, input logic ev, input logic [3:0] rob,
                      input logic [31:0] val, input logic yu);
    @(negedge clk);
    flush = fl; enq_valid = ev; yumi_in = yu; enq_packet = mk(rob, val);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t first;
    CDB_packet_t exp_p;

    first.fl = 0; first.ev = 1; first.rob = 4'h5; first.val = 32'hDEAD_BEEF; first.yu = 0;
    first.exp_v = 1; first.exp_r = 1; first.exp_cnt = 1;
    first.exp_rob = 4'h5; first.exp_val = 32'hDEAD_BEEF;
    vecs.push_back(first);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 1, 1, 1);
    add(0, 1, 2, 0, 1, 1, 2, 1);
    add(0, 1, 3, 0, 1, 1, 3, 1);
    add(0, 1, 4, 0, 1, 0, 4, 1);
    add(0, 1, 5, 0, 1, 0, 4, 1);
    add(0, 0, 0, 1, 1, 1, 3, 2);
    add(0, 0, 0, 1, 1, 1, 2, 3);
    add(0, 0, 0, 1, 1, 1, 1, 4);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 10, 0, 1, 1, 1, 10);
    add(0, 1, 11, 0, 1, 1, 2, 10);
    add(0, 1, 12, 1, 1, 1, 2, 11);
    for (int k = 13; k <= 20; k++) add(0, 1, 32'(k), 1, 1, 1, 2, 32'(k - 1));
    add(0, 1, 21, 0, 1, 1, 3, 19);
    add(0, 1, 22, 0, 1, 0, 4, 19);
    add(0, 1, 23, 1, 1, 1, 3, 20);
    add(1, 1, 24, 1, 0, 1, 0, 0);
    add(0, 1, 7, 0, 1, 1, 1, 7);
    add(0, 0, 0, 1, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("in reset", 0, 1, 0, '0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk_out("after reset", 0, 1, 0, '0);

    foreach (vecs[i]) begin
      step(vecs[i].fl, vecs[i].ev, vecs[i].rob, vecs[i].val, vecs[i].yu);
      exp_p = vecs[i].exp_v ? mk(vecs[i].exp_rob, vecs[i].exp_val) : '0;
      chk_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_r, vecs[i].exp_cnt, exp_p);
    end

    step(0, 1, 4'h1, 32'h100, 0);
    step(0, 1, 4'h2, 32'h200, 0);
    step(0, 1, 4'h3, 32'h300, 0);
    chk("pre-reset count", 128'(count), 128'(3));
    @(negedge clk);
    enq_valid = 0;
    #2;
    reset = 0;
    #1;
    chk_out("async reset", 0, 1, 0, '0);
    @(negedge clk);
    reset = 1;
    step(0, 1, 4'h9, 32'h999, 0);
    chk_out("post async reset enq", 1, 1, 1, mk(4'h9, 32'h999));
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
